// File: rtl/gate_truth_checker.sv
// Sweeps every input vector of a small logic gate, waits a settle time, then
// compares the gate output against an expected truth table and reports the result.
module gate_truth_checker #(
  parameter int N_IN       = 2,
  parameter int SETTLE_CYC = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2**N_IN-1:0]    exp_table,
  output logic [N_IN-1:0]       dut_in,
  input  logic                  dut_out,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [N_IN:0]         err_count,
  output logic [N_IN-1:0]       fail_vec
);

  localparam int NV = 2**N_IN;
  // A one-bit counter is still needed when the settle time is a single cycle.
  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [N_IN-1:0]   vec;
  logic [CW-1:0]     cnt;
  logic              mismatch;
  logic              last_vec;
  logic              settled;

  assign mismatch = (dut_out != exp_table[vec]);
  assign last_vec = (vec == {N_IN{1'b1}});
  assign settled  = (cnt == CW'(SETTLE_CYC - 1));
  assign dut_in   = vec;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        busy = 1'b1;
        if (settled) begin
          state_next = SAMPLE;
        end
      end
      SAMPLE: begin
        busy       = 1'b1;
        state_next = last_vec ? DONE : SETTLE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // pass is resolved on the final compare so it is already valid while done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec       <= '0;
      cnt       <= '0;
      err_count <= '0;
      fail_vec  <= '0;
      pass      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            vec       <= '0;
            cnt       <= '0;
            err_count <= '0;
            fail_vec  <= '0;
            pass      <= 1'b0;
          end
        end
        SETTLE: begin
          cnt <= cnt + CW'(1);
        end
        SAMPLE: begin
          if (mismatch) begin
            if (err_count != (N_IN+1)'(NV)) begin
              err_count <= err_count + (N_IN+1)'(1);
            end
            if (err_count == '0) begin
              fail_vec <= vec;
            end
          end
          if (last_vec) begin
            pass <= (err_count == '0) && !mismatch;
          end else begin
            vec <= vec + N_IN'(1);
            cnt <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: table-driven and random sweeps against a truth-table
// gate model, plus reset, slow-settle and held-start sequences.
module tb_gate_truth_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] gate_tbl;

  logic       start_f, start_s;
  logic [3:0] exp_f, exp_s;
  logic [1:0] dut_in_f, dut_in_s;
  logic       dut_out_f, dut_out_s;
  logic       busy_f, busy_s, done_f, done_s, pass_f, pass_s;
  logic [2:0] err_f, err_s;
  logic [1:0] fvec_f, fvec_s;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string      name;
    logic [3:0] gate;
    logic [3:0] expv;
    int         e_err;
    int         e_fvec;
    int         e_pass;
  } vec_t;

  vec_t tbl[7];

  always #5 clk = ~clk;

  // The gate under test is modelled as a truth table indexed by {a,b}.
  assign dut_out_f = gate_tbl[dut_in_f];
  assign dut_out_s = gate_tbl[dut_in_s];

  gate_truth_checker u_fast (
    .clk(clk), .rst(rst), .start(start_f), .exp_table(exp_f), .dut_in(dut_in_f),
    .dut_out(dut_out_f), .busy(busy_f), .done(done_f), .pass(pass_f),
    .err_count(err_f), .fail_vec(fvec_f)
  );

  gate_truth_checker #(.N_IN(2), .SETTLE_CYC(3)) u_slow (
    .clk(clk), .rst(rst), .start(start_s), .exp_table(exp_s), .dut_in(dut_in_s),
    .dut_out(dut_out_s), .busy(busy_s), .done(done_s), .pass(pass_s),
    .err_count(err_s), .fail_vec(fvec_s)
  );

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Reference: mismatches are the set bits of gate^exp; the first failure is the lowest one.
  function automatic void model(input logic [3:0] gate, input logic [3:0] expv,
                                output int e_err, output int e_fvec, output int e_pass);
    e_err  = 0;
    e_fvec = -1;
    for (int i = 0; i < 4; i++) begin
      if (gate[i] != expv[i]) begin
        e_err++;
        if (e_fvec < 0) e_fvec = i;
      end
    end
    if (e_fvec < 0) e_fvec = 0;
    e_pass = (e_err == 0) ? 1 : 0;
  endfunction

  task automatic apply_stimulus(input string name, input logic [3:0] gate, input logic [3:0] expv,
                                input int e_err, input int e_fvec, input int e_pass);
    int done_cyc;
    done_cyc = -1;
    @(negedge clk);
    gate_tbl = gate;
    exp_f    = expv;
    start_f  = 1'b1;
    @(posedge clk);
    #1;
    start_f = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if ((c % 2 == 1) && (c < 9)) check_output($sformatf("%s dut_in c%0d", name, c), dut_in_f, (c - 1) / 2);
      if (c == 1) check_output({name, " busy c1"}, busy_f, 1);
      if (done_f) begin
        done_cyc = c;
        break;
      end
      @(posedge clk);
      #1;
    end
    check_output({name, " done cycle"}, done_cyc, 9);
    check_output({name, " busy in done"}, busy_f, 0);
    check_output({name, " dut_in hold"}, dut_in_f, 3);
    check_output({name, " err_count"}, err_f, e_err);
    check_output({name, " pass"}, pass_f, e_pass);
    if (e_pass == 0) check_output({name, " fail_vec"}, fvec_f, e_fvec);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e_err, e_fvec, e_pass, done_cyc;
    logic [3:0] g, x;

    tbl[0] = '{"nor_ok",    4'b0001, 4'b0001, 0, 0, 1};
    tbl[1] = '{"nor_vs_or", 4'b0001, 4'b1110, 4, 0, 0};
    tbl[2] = '{"and_b1",    4'b1100, 4'b1000, 1, 2, 0};
    tbl[3] = '{"xor_ok",    4'b0110, 4'b0110, 0, 0, 1};
    tbl[4] = '{"xnor_bad",  4'b1001, 4'b0110, 4, 0, 0};
    tbl[5] = '{"nand_ok",   4'b0111, 4'b0111, 0, 0, 1};
    tbl[6] = '{"or_v0bad",  4'b1110, 4'b1111, 1, 0, 0};

    rst = 1'b1; start_f = 1'b0; start_s = 1'b0;
    exp_f = 4'b0; exp_s = 4'b0; gate_tbl = 4'b0001;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset dut_in", dut_in_f, 0);
    check_output("reset busy", busy_f, 0);
    check_output("reset done", done_f, 0);
    check_output("reset pass", pass_f, 0);
    check_output("reset err_count", err_f, 0);
    check_output("reset fail_vec", fvec_f, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      apply_stimulus(tbl[i].name, tbl[i].gate, tbl[i].expv, tbl[i].e_err, tbl[i].e_fvec, tbl[i].e_pass);
    end

    for (int i = 0; i < 20; i++) begin
      g = 4'($urandom_range(0, 15));
      x = (i % 3 == 0) ? g : 4'($urandom_range(0, 15));
      model(g, x, e_err, e_fvec, e_pass);
      apply_stimulus($sformatf("rand%0d", i), g, x, e_err, e_fvec, e_pass);
    end

    // Reset in cycle 4 of a failing sweep discards the partial result.
    @(negedge clk);
    gate_tbl = 4'b0001; exp_f = 4'b1110; start_f = 1'b1;
    @(posedge clk);
    #1;
    start_f = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check_output("pre-rst err_count", err_f, 1);
    check_output("pre-rst dut_in", dut_in_f, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_output("rst dut_in", dut_in_f, 0);
    check_output("rst err_count", err_f, 0);
    check_output("rst busy", busy_f, 0);
    check_output("rst done", done_f, 0);
    check_output("rst pass", pass_f, 0);
    @(posedge clk);
    #1;
    check_output("rst stays idle", busy_f, 0);
    apply_stimulus("post_rst", 4'b0001, 4'b0001, 0, 0, 1);

    // SETTLE_CYC=3 instance, with a start pulse mid-sweep that must be ignored.
    done_cyc = -1;
    @(negedge clk);
    gate_tbl = 4'b0001; exp_s = 4'b0001; start_s = 1'b1;
    @(posedge clk);
    #1;
    start_s = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if ((c % 4 == 1) && (c < 17)) check_output($sformatf("slow dut_in c%0d", c), dut_in_s, (c - 1) / 4);
      if (c == 5) start_s = 1'b1;
      if (c == 6) start_s = 1'b0;
      if (done_s) begin
        done_cyc = c;
        break;
      end
      @(posedge clk);
      #1;
    end
    check_output("slow done cycle", done_cyc, 17);
    check_output("slow pass", pass_s, 1);
    check_output("slow err_count", err_s, 0);
    @(posedge clk);
    #1;

    // start held high: back-to-back sweeps, results cleared on each accepted start.
    done_cyc = -1;
    @(negedge clk);
    gate_tbl = 4'b0001; exp_f = 4'b0001; start_f = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 1; c <= 60; c++) begin
      if (c == 9) begin
        check_output("held done c9", done_f, 1);
        check_output("held pass c9", pass_f, 1);
      end
      if (c == 10) exp_f = 4'b1110;
      if (c == 11) begin
        check_output("held pass cleared", pass_f, 0);
        check_output("held err cleared", err_f, 0);
        check_output("held busy c11", busy_f, 1);
      end
      if (c > 10 && done_f) begin
        done_cyc = c;
        break;
      end
      @(posedge clk);
      #1;
    end
    start_f = 1'b0;
    check_output("held second done cycle", done_cyc, 19);
    check_output("held second err_count", err_f, 4);
    check_output("held second pass", pass_f, 0);
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
